// File: rtl/wxyz_code_sequencer_if.sv
// Code bus from the sequencer to the W/X/Y/Z detect stage: 4 code bits, index and valid/ready handshake.
interface wxyz_code_sequencer_if;
  logic       W;
  logic       X;
  logic       Y;
  logic       Z;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] code_index;

  modport master (
    output W, X, Y, Z, out_valid, code_index,
    input  out_ready
  );

  modport slave (
    input  W, X, Y, Z, out_valid, code_index,
    output out_ready
  );
endinterface

// File: rtl/wxyz_code_sequencer.sv
// Steps 4-bit codes (binary/BCD/Gray) onto W,X,Y,Z: first code one cycle after start, then every HOLD_CYCLES+1 cycles.
// Code is offered with out_valid until out_ready; `SEQ_PAUSE_EN adds a pause input that freezes the HOLD count.
module wxyz_code_sequencer #(
  parameter logic [3:0] START_CODE  = 4'b1000,
  parameter int         NUM_CODES   = 16,
  parameter int         HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
`ifdef SEQ_PAUSE_EN
  input  logic       pause,
`endif
  input  logic       start,
  input  logic [1:0] mode,
  output logic       busy,
  output logic       done,
  wxyz_code_sequencer_if.master bus
);
  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [4:0]    IDX_LAST  = 5'(NUM_CODES - 1);
  localparam logic [1:0]    MODE_BCD  = 2'b01;
  localparam logic [1:0]    MODE_GRAY = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_HOLD, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    seq_q, seq_d;
  logic [4:0]    idx_q, idx_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    mode_q, mode_d;
  logic [3:0]    wxyz_q, wxyz_d;
  logic [3:0]    seq_init, seq_adv;
  logic          hold_run;

  // BCD cannot represent a start code above 9, so such a run begins at 0.
  function automatic logic [3:0] first_seq(input logic [1:0] m);
    return (m == MODE_BCD && START_CODE > 4'd9) ? 4'd0 : START_CODE;
  endfunction

  function automatic logic [3:0] next_seq(input logic [3:0] s, input logic [1:0] m);
    if (m == MODE_BCD) return (s >= 4'd9) ? 4'd0 : s + 4'd1;
    return s + 4'd1;
  endfunction

  function automatic logic [3:0] encode(input logic [3:0] s, input logic [1:0] m);
    return (m == MODE_GRAY) ? (s ^ (s >> 1)) : s;
  endfunction

`ifdef SEQ_PAUSE_EN
  assign hold_run = ~pause;
`else
  assign hold_run = 1'b1;
`endif

  assign seq_init = first_seq(mode);
  assign seq_adv  = next_seq(seq_q, mode_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      seq_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      mode_q  <= '0;
      wxyz_q  <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
      wxyz_q  <= wxyz_d;
    end
  end

  // wxyz only updates on the edge entering PRESENT, so it is stable whenever out_valid is high.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
    wxyz_d  = wxyz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          seq_d   = seq_init;
          idx_d   = '0;
          mode_d  = mode;
          wxyz_d  = encode(seq_init, mode);
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (bus.out_ready) begin
          hold_d  = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_run) begin
          if (hold_q == HOLD_LAST) begin
            if (idx_q == IDX_LAST) begin
              state_d = S_DONE;
            end else begin
              seq_d   = seq_adv;
              idx_d   = idx_q + 5'd1;
              wxyz_d  = encode(seq_adv, mode_q);
              state_d = S_PRESENT;
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.W          = wxyz_q[3];
  assign bus.X          = wxyz_q[2];
  assign bus.Y          = wxyz_q[1];
  assign bus.Z          = wxyz_q[0];
  assign bus.out_valid  = (state_q == S_PRESENT);
  assign bus.code_index = idx_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
endmodule

// File: tb/tb_wxyz_code_sequencer.sv
// Randomized bench for wxyz_code_sequencer; expected codes come from a closed-form sequence model.
module tb_wxyz_code_sequencer;
  localparam logic [3:0] START_CODE  = 4'b1000;
  localparam int         NUM_CODES   = 16;
  localparam int         HOLD_CYCLES = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
`ifdef SEQ_PAUSE_EN
  logic       pause;
`endif
  logic       busy;
  logic       done;
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;

  wxyz_code_sequencer_if bus();

  wxyz_code_sequencer #(
    .START_CODE (START_CODE),
    .NUM_CODES  (NUM_CODES),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef SEQ_PAUSE_EN
    .pause(pause),
`endif
    .start(start),
    .mode (mode),
    .busy (busy),
    .done (done),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // i-th code of a run: count up from the start value modulo 16 (or 10 for BCD), Gray-encode if asked.
  function automatic logic [3:0] model_code(input logic [1:0] m, input int i);
    int s0;
    int s;
    s0 = int'(START_CODE);
    if (m == 2'b01 && s0 > 9) s0 = 0;
    s = (m == 2'b01) ? (s0 + i) % 10 : (s0 + i) % 16;
    if (m == 2'b10) s = s ^ (s >> 1);
    return 4'(s);
  endfunction

  function automatic logic [3:0] wxyz();
    return {bus.W, bus.X, bus.Y, bus.Z};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({wxyz(), bus.out_valid, busy, done, bus.code_index} !== 12'd0) begin
      failures++;
      $display("FAIL reset_state: got wxyz=%b valid=%b busy=%b done=%b idx=%0d required all zero",
               wxyz(), bus.out_valid, busy, done, bus.code_index);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sequence(input logic [1:0] m, input bit rand_ready);
    int         k         = 0;
    int         last      = -1;
    bit         prev_vld  = 1'b0;
    bit         seen_done = 1'b0;
    int         after     = 0;
    logic [3:0] prev_code = '0;
    logic [4:0] prev_idx  = '0;
    mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL start_latency: got out_valid=%b required 1", bus.out_valid);
    end
    for (int cycle = 0; cycle < 4000 && after < 3; cycle++) begin
      mode = 2'($urandom_range(0, 3));
      if (seen_done) begin
        after++;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          failures++;
          $display("FAIL after_done: got busy=%b done=%b required 0 0", busy, done);
        end
      end else if (bus.out_valid === 1'b1) begin
        if (prev_vld) begin
          checks++;
          if (wxyz() !== prev_code || bus.code_index !== prev_idx) begin
            failures++;
            $display("FAIL stable_while_valid: got %b/%0d required %b/%0d", wxyz(), bus.code_index, prev_code, prev_idx);
          end
        end else begin
          checks++;
          if (wxyz() !== model_code(m, k)) begin
            failures++;
            $display("FAIL code_m%0d_k%0d: got %b required %b", m, k, wxyz(), model_code(m, k));
          end
          checks++;
          if (bus.code_index !== 5'(k) || busy !== 1'b1) begin
            failures++;
            $display("FAIL index_k%0d: got idx=%0d busy=%b required idx=%0d busy=1", k, bus.code_index, busy, k);
          end
        end
        bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.out_ready) begin
          if (!rand_ready && last >= 0) begin
            checks++;
            if (cyc - last !== HOLD_CYCLES + 1) begin
              failures++;
              $display("FAIL code_period: got %0d required %0d", cyc - last, HOLD_CYCLES + 1);
            end
          end
          last = cyc;
          k++;
        end
      end else begin
        bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (!seen_done && done === 1'b1) begin
        seen_done = 1'b1;
        checks++;
        if (k !== NUM_CODES) begin
          failures++;
          $display("FAIL done_count: got %0d transfers required %0d", k, NUM_CODES);
        end
      end
      prev_vld  = (bus.out_valid === 1'b1);
      prev_code = wxyz();
      prev_idx  = bus.code_index;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    checks++;
    if (!seen_done) begin
      failures++;
      $display("FAIL run_timeout: got no done pulse required one");
    end
    checks++;
    if (wxyz() !== model_code(m, NUM_CODES - 1)) begin
      failures++;
      $display("FAIL idle_retain: got %b required %b", wxyz(), model_code(m, NUM_CODES - 1));
    end
  endtask

  task automatic test_backpressure();
    int  lows  = 0;
    bit  found = 1'b0;
    mode = 2'b00;
    bus.out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (bus.out_valid === 1'b1 && bus.code_index === 5'd3) found = 1'b1;
      else @(negedge clk);
    end
    bus.out_ready = 1'b0;
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL bp_reach: got no presentation of index 3 required one");
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || wxyz() !== 4'b1011 || bus.code_index !== 5'd3) begin
        failures++;
        $display("FAIL bp_hold_%0d: got valid=%b wxyz=%b idx=%0d required 1 1011 3", i, bus.out_valid, wxyz(), bus.code_index);
      end
      if (i < 4) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || wxyz() !== 4'b1011) begin
      failures++;
      $display("FAIL bp_release: got valid=%b wxyz=%b required 0 1011", bus.out_valid, wxyz());
    end
    for (int c = 0; c < 50 && bus.out_valid !== 1'b1; c++) begin
      lows++;
      @(negedge clk);
    end
    checks++;
    if (lows !== HOLD_CYCLES || wxyz() !== 4'b1100) begin
      failures++;
      $display("FAIL bp_next: got hold=%0d wxyz=%b required %0d 1100", lows, wxyz(), HOLD_CYCLES);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit found = 1'b0;
    mode = 2'b00;
    bus.out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      if (bus.out_valid === 1'b0 && busy === 1'b1 && bus.code_index === 5'd6) found = 1'b1;
      else @(negedge clk);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (!found || {wxyz(), bus.out_valid, busy, done, bus.code_index} !== 12'd0) begin
      failures++;
      $display("FAIL mid_reset: got found=%b wxyz=%b valid=%b busy=%b done=%b idx=%0d required all zero",
               found, wxyz(), bus.out_valid, busy, done, bus.code_index);
    end
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || wxyz() !== 4'b1000 || bus.code_index !== 5'd0) begin
      failures++;
      $display("FAIL restart: got valid=%b wxyz=%b idx=%0d required 1 1000 0", bus.out_valid, wxyz(), bus.code_index);
    end
  endtask

  task automatic test_start_ignored();
    // Continues the run begun in test_reset_mid_run; a start pulse in HOLD must not restart it.
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 50 && bus.out_valid !== 1'b1; c++) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.code_index !== 5'd1 || wxyz() !== 4'b1001) begin
      failures++;
      $display("FAIL start_ignored: got valid=%b idx=%0d wxyz=%b required 1 1 1001", bus.out_valid, bus.code_index, wxyz());
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef SEQ_PAUSE_EN
  task automatic test_pause();
    int first;
    int h = 0;
    mode = 2'b00;
    bus.out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first = cyc;
    @(negedge clk);
    for (int c = 0; c < 60 && bus.out_valid !== 1'b1; c++) begin
      h++;
      pause = (h >= 3 && h < 7);
      @(negedge clk);
    end
    pause = 1'b0;
    checks++;
    if (cyc - first !== HOLD_CYCLES + 5) begin
      failures++;
      $display("FAIL pause_period: got %0d required %0d", cyc - first, HOLD_CYCLES + 5);
    end
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pause_in_present: got valid=%b busy=%b required 0 1", bus.out_valid, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 2'b00;
    bus.out_ready = 1'b0;
`ifdef SEQ_PAUSE_EN
    pause = 1'b0;
`endif
    test_reset();
    test_sequence(2'b00, 1'b0);
    test_sequence(2'b01, 1'b0);
    test_sequence(2'b10, 1'b0);
    test_sequence(2'b11, 1'b1);
    test_sequence(2'($urandom_range(0, 3)), 1'b1);
    test_backpressure();
    test_reset_mid_run();
    test_start_ignored();
`ifdef SEQ_PAUSE_EN
    test_pause();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
